mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified synchronous single-port memory between the core's instruction-fetch port and its data port (byte-enabled load/store).
- Sits between the MIPS core and a unified memory, replacing separate inst/data memories.
- Sequences each access: grant, issue, fixed-latency wait, response; acks the requester with read data.
- Core stalls on its own req until ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SW = DW/8 byte selects.
- MEM_LAT, 1, memory read latency in cycles (legal 1..7); m_rdata valid MEM_LAT cycles after the m_en cycle.
- STARVE_MAX, 4, consecutive lost arbitrations before instruction port is forced (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction fetch request; held with i_addr until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched word, valid when i_ack
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held with fields until d_ack
- d_we  in  1  1 = store, 0 = load
- d_sel  in  SW  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_ack
- d_ack  out  1  one-cycle completion pulse
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_sel  out  SW  memory byte enables
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
- IDLE: if d_req or i_req, choose winner (data beats instruction by default); latch owner and fields into m_addr/m_we/m_sel/m_wdata; go ISSUE.
  - Inst grant: m_we=0, m_sel=all ones.
  - Data grant: m_we=d_we, m_sel=d_sel.
- ISSUE: m_en=1 for exactly this cycle; load counter with MEM_LAT; go WAIT.
- WAIT: counter decrements each cycle; at the edge where it reaches 0, capture m_rdata into owner's rdata register and go RESP.
  - Store: rdata register unchanged.
- RESP: owner's ack=1 for this cycle only; no arbitration; go IDLE.
- Latency: request seen in IDLE cycle 0 -> m_en in cycle 1 -> ack in cycle MEM_LAT+2. Throughput: one transaction per MEM_LAT+3 cycles.
- Fields are sampled only at grant; changes while busy are ignored.
- i_ack and d_ack are never high together. m_en is never high outside ISSUE.
- Store with d_sel=0: still issued (m_we=1, m_sel=0) and acked; memory contents unchanged.
- Simultaneous requests: one granted; loser is granted on the next IDLE visit if still asserted.
- Reset (any state, including mid-transaction):
  - state=IDLE, m_en=0, m_we=0, m_sel=0, m_addr=0, m_wdata=0.
  - i_ack=d_ack=0, i_rdata=d_rdata=0, busy=0, counters=0.
  - In-flight transaction is dropped with no ack.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - Saturating starve counter increments each grant to data while i_req is high; clears on any inst grant.
  - When counter == STARVE_MAX and i_req is high, the next grant goes to instruction regardless of d_req.
  - Counter resets to 0.
- Undefined: strict data-over-instruction priority; starve counter logic absent.

Test Plan:
- Single fetch, MEM_LAT=1, memory word 0x100 = 0x2402000A; i_req with i_addr=0x100 in cycle 0 -> m_en=1, m_addr=0x100, m_sel=4'hF in cycle 1; i_ack=1, i_rdata=0x2402000A in cycle 3; busy low in cycle 4.
- Store then load: store d_addr=0x40, d_sel=4'b0011, d_wdata=0x0000BEEF over old 0x12345678; d_ack=1 in cycle 3; then load 0x40 -> d_rdata=0x1234BEEF.
- Collision: i_req and d_req both asserted in cycle 0 -> d_ack in cycle 3, i_ack in cycle 7; never both acks in the same cycle.
- Reset during WAIT, MEM_LAT=4: rst high in cycle 3 -> next cycle all outputs 0, busy=0, no ack ever for that request.
- ARB_FAIR_EN, STARVE_MAX=4: d_req and i_req held continuously -> grant order D,D,D,D,I,D,...
- Same stimulus without ARB_FAIR_EN -> i_ack never asserted while d_req stays high.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core fetch/data request ports and unified memory bus seen by mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic [SW-1:0] d_sel;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          m_en;
  logic          m_we;
  logic [SW-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_sel, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_sel, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory between fetch and data ports; ARB_FAIR_EN enables anti-starvation
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       owner_d;
  logic       grant_d;
  logic       force_i;

`ifdef ARB_FAIR_EN
  localparam int STW = $clog2(STARVE_MAX + 1);
  logic [STW-1:0] starve;

  assign force_i = (starve == STW'(STARVE_MAX)) && bus.i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (state == IDLE && state_n == ISSUE) begin
      if (!grant_d)
        starve <= '0;
      else if (bus.i_req && starve != STW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end
`else
  assign force_i = 1'b0 && (STARVE_MAX > 0);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          state_n = ISSUE;
          grant_d = bus.d_req && !force_i;
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = 3'(MEM_LAT);
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1)
          state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every output is a register; the next-state decode drives their update so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_d     <= 1'b0;
      busy        <= 1'b0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_sel   <= '0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      busy      <= (state_n != IDLE);
      bus.m_en  <= (state_n == ISSUE);
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      if (state == IDLE && state_n == ISSUE) begin
        owner_d     <= grant_d;
        bus.m_addr  <= grant_d ? bus.d_addr : bus.i_addr;
        bus.m_we    <= grant_d && bus.d_we;
        bus.m_sel   <= grant_d ? bus.d_sel : '1;
        bus.m_wdata <= grant_d ? bus.d_wdata : '0;
      end
      if (state == WAIT && state_n == RESP) begin
        if (owner_d) begin
          if (!bus.m_we)
            bus.d_rdata <= bus.m_rdata;
          bus.d_ack <= 1'b1;
        end else begin
          bus.i_rdata <= bus.m_rdata;
          bus.i_ack   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=4 instances)
module tb_mem_arbiter;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst4 = 1'b1;
  logic busy1, busy4;
  int   n_checks = 0;
  int   n_errors = 0;
  int   both_ack = 0;
  int   men_run  = 0;
  logic men_prev = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus4 ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1));
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_MAX(4)) u4 (
    .clk(clk), .rst(rst4), .bus(bus4), .busy(busy4));

  // One-cycle-latency byte-enabled memory for u1; u4 only ever sees a constant word.
  logic [31:0] mem [0:255];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[8'h40] <= 32'h2402000A;
      mem[8'h10] <= 32'h12345678;
    end else if (bus1.m_en) begin
      bus1.m_rdata <= mem[bus1.m_addr[9:2]];
      if (bus1.m_we)
        for (int b = 0; b < 4; b++)
          if (bus1.m_sel[b]) mem[bus1.m_addr[9:2]][8*b +: 8] <= bus1.m_wdata[8*b +: 8];
    end
  end
  assign bus4.m_rdata = 32'hDEADBEEF;

  always @(negedge clk) begin
    if (bus1.i_ack && bus1.d_ack) both_ack++;
    if (bus1.m_en && men_prev) men_run++;
    men_prev = bus1.m_en;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = u1 fetch, 1 = u1 data, 2 = u4 data; returns the cycle of the ack or -1
  task automatic wait_ack(input int sel, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((sel == 0 && bus1.i_ack) || (sel == 1 && bus1.d_ack) || (sel == 2 && bus4.d_ack)) begin
        cyc = c;
        break;
      end
    end
  endtask

  int cyc, d_cyc, i_cyc, grants, acks4, busy4_cnt;
  logic [5:0] order;
  logic [5:0] exp_order;

  initial begin
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_sel = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus4.i_req = 0; bus4.i_addr = '0; bus4.d_req = 0; bus4.d_we = 0;
    bus4.d_sel = '0; bus4.d_addr = '0; bus4.d_wdata = '0;
    tick(); tick();
    check("rst_busy", busy1, 0);
    check("rst_men", bus1.m_en, 0);
    check("rst_acks", {bus1.i_ack, bus1.d_ack}, 0);
    check("rst_rdata", {bus1.i_rdata, bus1.d_rdata}, 0);
    rst = 0; rst4 = 0;
    tick();

    // single fetch
    bus1.i_req = 1; bus1.i_addr = 32'h100;
    tick();
    check("f_men", bus1.m_en, 1);
    check("f_maddr", bus1.m_addr, 32'h100);
    check("f_msel", bus1.m_sel, 4'hF);
    check("f_mwe", bus1.m_we, 0);
    check("f_busy", busy1, 1);
    tick();
    check("f_men_drop", bus1.m_en, 0);
    check("f_noack_c2", bus1.i_ack, 0);
    tick();
    check("f_iack", bus1.i_ack, 1);
    check("f_irdata", bus1.i_rdata, 32'h2402000A);
    bus1.i_req = 0;
    tick();
    check("f_ack_pulse", bus1.i_ack, 0);
    check("f_idle", busy1, 0);

    // partial store then load
    bus1.d_req = 1; bus1.d_we = 1; bus1.d_sel = 4'b0011;
    bus1.d_addr = 32'h40; bus1.d_wdata = 32'h0000BEEF;
    tick();
    check("st_mwe", bus1.m_we, 1);
    check("st_msel", bus1.m_sel, 4'b0011);
    check("st_mwdata", bus1.m_wdata, 32'h0000BEEF);
    tick(); tick();
    check("st_dack", bus1.d_ack, 1);
    check("st_rdata_kept", bus1.d_rdata, 0);
    bus1.d_req = 0;
    tick();
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_sel = 4'hF;
    wait_ack(1, cyc);
    check("ld_cycle", cyc, 3);
    check("ld_rdata", bus1.d_rdata, 32'h1234BEEF);
    bus1.d_req = 0;
    tick();

    // collision: data first, fetch on the next IDLE visit
    d_cyc = -1; i_cyc = -1;
    bus1.d_req = 1; bus1.i_req = 1; bus1.i_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus1.d_ack) begin d_cyc = c; bus1.d_req = 0; end
      if (bus1.i_ack) begin i_cyc = c; bus1.i_req = 0; end
    end
    check("col_dack", d_cyc, 3);
    check("col_iack", i_cyc, 7);
    check("col_irdata", bus1.i_rdata, 32'h2402000A);

    // sustained contention
    order = '0; grants = 0;
    bus1.d_req = 1; bus1.i_req = 1;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      tick();
      if (bus1.i_ack || bus1.d_ack) begin
        order[grants] = bus1.i_ack;
        grants++;
      end
    end
    bus1.d_req = 0; bus1.i_req = 0;
    tick(); tick();
`ifdef ARB_FAIR_EN
    exp_order = 6'b010000;
`else
    exp_order = 6'b000000;
`endif
    check("fair_grants", grants, 6);
    check("fair_order", order, exp_order);
    check("ack_exclusive", both_ack, 0);
    check("men_single", men_run, 0);

    // MEM_LAT=4: load latency, then reset during a store's WAIT
    bus4.d_req = 1; bus4.d_we = 0; bus4.d_sel = 4'hF; bus4.d_addr = 32'h80;
    wait_ack(2, cyc);
    check("l4_cycle", cyc, 6);
    check("l4_rdata", bus4.d_rdata, 32'hDEADBEEF);
    bus4.d_req = 0;
    tick();
    bus4.d_req = 1; bus4.d_we = 1; bus4.d_wdata = 32'hA5A5A5A5;
    tick(); tick(); tick();
    check("r4_busy_pre", busy4, 1);
    check("r4_maddr_pre", bus4.m_addr, 32'h80);
    rst4 = 1; bus4.d_req = 0;
    tick();
    check("r4_bus_zero", {bus4.m_en, bus4.m_we, bus4.m_sel, bus4.m_addr, bus4.m_wdata}, 0);
    check("r4_core_zero", {bus4.i_ack, bus4.d_ack, busy4}, 0);
    check("r4_rdata_zero", {bus4.i_rdata, bus4.d_rdata}, 0);
    rst4 = 0;
    acks4 = 0; busy4_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus4.d_ack || bus4.i_ack) acks4++;
      if (busy4) busy4_cnt++;
    end
    check("r4_no_ack", acks4, 0);
    check("r4_stays_idle", busy4_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
